// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared definitions for the multi-cycle shift sequencer.
//   DW/AW     data width and shift-amount width (fixed 32/5 for this revision)
//   state_t   sequencer FSM states
//   stage_t   stage index k (4 down to 0, one binary-weighted stage per clock)
// Optional feature macro used by the design files: SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [2:0] stage_t;

   localparam stage_t K_MAX = 3'd4;

endpackage

// File: rtl/shift_seq_stage.sv
// shift_seq_stage: one combinational binary-weighted shift stage (shift by 2^k).
// Ports:
//   work_i  in   DW  current work value
//   dir_i   in   1   1 = arithmetic right, 0 = logical left
//   k_i     in   3   stage index, shift distance is 2^k_i
//   en_i    in   1   amount bit for this stage; 0 passes work_i through
//   rot_i   in   1   rotate instead of shift (only with SHIFT_SEQ_ROTATE_EN)
//   work_o  out  DW  next work value
// Macro: SHIFT_SEQ_ROTATE_EN adds rot_i.
module shift_seq_stage
   import shift_seq_pkg::*;
(
   input  logic [DW-1:0] work_i,
   input  logic          dir_i,
   input  stage_t        k_i,
   input  logic          en_i,
`ifdef SHIFT_SEQ_ROTATE_EN
   input  logic          rot_i,
`endif
   output logic [DW-1:0] work_o
);

   localparam logic [AW:0] DW_SH = (AW+1)'(DW);

   logic [AW:0]          sh;
   logic signed [DW-1:0] s_work;

   always_comb begin
      sh     = {{AW{1'b0}}, 1'b1} << k_i;
      s_work = work_i;
      work_o = work_i;
      if (en_i) begin
`ifdef SHIFT_SEQ_ROTATE_EN
         if (rot_i) begin
            // Bits leaving one end re-enter at the other.
            if (dir_i) begin
               work_o = (work_i >> sh) | (work_i << (DW_SH - sh));
            end else begin
               work_o = (work_i << sh) | (work_i >> (DW_SH - sh));
            end
         end else if (dir_i) begin
            s_work = s_work >>> sh;
            work_o = s_work;
         end else begin
            work_o = work_i << sh;
         end
`else
         if (dir_i) begin
            // Kept as a separate signed statement so the sign fill is not lost to context.
            s_work = s_work >>> sh;
            work_o = s_work;
         end else begin
            work_o = work_i << sh;
         end
`endif
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: 32-bit multi-cycle shifter, one binary-weighted stage
// (16, 8, 4, 2, 1) per clock, with request/response handshakes.
// Fixed latency: RSP_VALID rises 6 edges after the accept edge.
// Ports:
//   CLK        in   1   clock, rising edge
//   RST_N      in   1   asynchronous active-low reset
//   REQ_VALID  in   1   request present
//   REQ_READY  out  1   idle, request can be accepted
//   SH_DIR     in   1   1 = arithmetic right, 0 = logical left
//   SH_AMT     in   5   shift amount
//   SH_ROT     in   1   rotate select (only with SHIFT_SEQ_ROTATE_EN)
//   D_IN       in   32  operand
//   RSP_VALID  out  1   result valid
//   RSP_READY  in   1   consumer accepts result
//   D_OUT      out  32  result, held after the handshake
//   BUSY       out  1   high in SHIFT or DONE
// Macro: SHIFT_SEQ_ROTATE_EN adds SH_ROT and rotate operation.
module shift_sequencer
   import shift_seq_pkg::*;
(
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic          SH_DIR,
   input  logic [AW-1:0] SH_AMT,
`ifdef SHIFT_SEQ_ROTATE_EN
   input  logic          SH_ROT,
`endif
   input  logic [DW-1:0] D_IN,
   output logic          RSP_VALID,
   input  logic          RSP_READY,
   output logic [DW-1:0] D_OUT,
   output logic          BUSY
);

   state_t        state_q, state_d;
   logic [DW-1:0] work_q, work_d;
   logic          dir_q, dir_d;
   logic [AW-1:0] amt_q, amt_d;
   stage_t        k_q, k_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] d_out_q, d_out_d;
   logic [DW-1:0] stage_out;
`ifdef SHIFT_SEQ_ROTATE_EN
   logic          rot_q, rot_d;
`endif

   shift_seq_stage u_stage (
      .work_i (work_q),
      .dir_i  (dir_q),
      .k_i    (k_q),
      .en_i   (amt_q[k_q]),
`ifdef SHIFT_SEQ_ROTATE_EN
      .rot_i  (rot_q),
`endif
      .work_o (stage_out)
   );

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         work_q      <= '0;
         dir_q       <= 1'b0;
         amt_q       <= '0;
         k_q         <= K_MAX;
         rsp_valid_q <= 1'b0;
         d_out_q     <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         dir_q       <= dir_d;
         amt_q       <= amt_d;
         k_q         <= k_d;
         rsp_valid_q <= rsp_valid_d;
         d_out_q     <= d_out_d;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_q       <= rot_d;
`endif
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      dir_d       = dir_q;
      amt_d       = amt_q;
      k_d         = k_q;
      rsp_valid_d = rsp_valid_q;
      d_out_d     = d_out_q;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_d       = rot_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               work_d  = D_IN;
               dir_d   = SH_DIR;
               amt_d   = SH_AMT;
               k_d     = K_MAX;
`ifdef SHIFT_SEQ_ROTATE_EN
               rot_d   = SH_ROT;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = stage_out;
            if (k_q == '0) begin
               state_d = DONE;
            end else begin
               k_d = k_q - 3'd1;
            end
         end
         DONE: begin
            // First DONE cycle registers the result; this is the sixth edge after accept.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               d_out_d     = work_q;
            end else if (RSP_READY) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      REQ_READY = (state_q == IDLE);
      BUSY      = (state_q != IDLE);
      RSP_VALID = rsp_valid_q;
      D_OUT     = d_out_q;
   end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

   logic        CLK;
   logic        RST_N;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        SH_DIR;
   logic [4:0]  SH_AMT;
`ifdef SHIFT_SEQ_ROTATE_EN
   logic        SH_ROT;
`endif
   logic [31:0] D_IN;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] D_OUT;
   logic        BUSY;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   shift_sequencer dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .SH_DIR    (SH_DIR),
      .SH_AMT    (SH_AMT),
`ifdef SHIFT_SEQ_ROTATE_EN
      .SH_ROT    (SH_ROT),
`endif
      .D_IN      (D_IN),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .D_OUT     (D_OUT),
      .BUSY      (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] model(input logic [31:0] d, input logic dir,
                                         input logic [4:0] amt, input logic rot);
      logic [63:0] dd;
      logic signed [31:0] s;
      dd = {d, d};
      if (rot) begin
         if (dir) begin
            dd = dd >> amt;
            return dd[31:0];
         end
         dd = dd << amt;
         return dd[63:32];
      end
      if (dir) begin
         s = d;
         s = s >>> amt;
         return s;
      end
      return d << amt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request; the accept edge is the posedge inside this task.
   task automatic issue(input logic [31:0] d, input logic dir, input logic [4:0] amt,
                        input logic rot, input bit push);
      @(negedge CLK);
      chk("req_ready_before", {31'd0, REQ_READY}, 32'd1);
      REQ_VALID = 1'b1;
      D_IN      = d;
      SH_DIR    = dir;
      SH_AMT    = amt;
`ifdef SHIFT_SEQ_ROTATE_EN
      SH_ROT    = rot;
`endif
      if (push) exp_q.push_back(model(d, dir, amt, rot));
      @(posedge CLK);
      #1;
      // Garbage on the inputs and a pending request must be ignored while busy.
      REQ_VALID = 1'b1;
      D_IN      = $urandom;
      SH_DIR    = 1'($urandom);
      SH_AMT    = 5'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
      SH_ROT    = 1'($urandom);
`endif
      chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
      chk("req_ready_after_accept", {31'd0, REQ_READY}, 32'd0);
   endtask

   task automatic wait_rsp(input int hold);
      int n;
      bit got;
      logic [31:0] exp;
      n   = 0;
      got = 0;
      while (n < 20 && !got) begin
         @(posedge CLK);
         #1;
         n++;
         if (RSP_VALID) got = 1;
      end
      chk("latency", 32'(n), 32'd6);
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("d_out", D_OUT, exp);
      chk("busy_done", {31'd0, BUSY}, 32'd1);
      repeat (hold) begin
         @(posedge CLK);
         #1;
         chk("hold_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
         chk("hold_d_out", D_OUT, exp);
         chk("hold_req_ready", {31'd0, REQ_READY}, 32'd0);
      end
      RSP_READY = 1'b1;
      @(posedge CLK);
      #1;
      RSP_READY = 1'b0;
      REQ_VALID = 1'b0;
      chk("post_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("post_req_ready", {31'd0, REQ_READY}, 32'd1);
      chk("post_busy", {31'd0, BUSY}, 32'd0);
      chk("post_d_out_kept", D_OUT, exp);
   endtask

   initial begin
      RST_N     = 1'b0;
      REQ_VALID = 1'b0;
      RSP_READY = 1'b0;
      SH_DIR    = 1'b0;
      SH_AMT    = '0;
      D_IN      = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      SH_ROT    = 1'b0;
`endif
      #12;
      chk("rst_req_ready", {31'd0, REQ_READY}, 32'd1);
      chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_d_out", D_OUT, 32'h0000_0000);
      @(negedge CLK);
      RST_N = 1'b1;

      // Left by 31.
      issue(32'h0000_0001, 1'b0, 5'd31, 1'b0, 1);
      chk("model_left31", exp_q[0], 32'h8000_0000);
      wait_rsp(0);
      // Arithmetic right.
      issue(32'h8000_0000, 1'b1, 5'd4, 1'b0, 1);
      wait_rsp(0);
      issue(32'h7000_0000, 1'b1, 5'd28, 1'b0, 1);
      wait_rsp(0);
      // Zero amount, same latency.
      issue(32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, 1);
      wait_rsp(0);
      issue(32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 1);
      wait_rsp(0);
      // Backpressure then back-to-back request.
      issue(32'h1234_5678, 1'b0, 5'd8, 1'b0, 1);
      wait_rsp(3);
      issue(32'hF0F0_0F0F, 1'b1, 5'd13, 1'b0, 1);
      wait_rsp(1);
      // Random mix.
      for (int i = 0; i < 8; i++) begin
         issue($urandom, 1'($urandom), 5'($urandom), 1'b0, 1);
         wait_rsp(int'($urandom_range(0, 2)));
      end

      // Reset while SHIFT holds k=2: discard, no response.
      issue(32'hCAFE_F00D, 1'b0, 5'd5, 1'b0, 0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST_N     = 1'b0;
      REQ_VALID = 1'b0;
      #1;
      chk("midrst_req_ready", {31'd0, REQ_READY}, 32'd1);
      chk("midrst_busy", {31'd0, BUSY}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("midrst_d_out", D_OUT, 32'h0000_0000);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) begin
         @(posedge CLK);
         #1;
         chk("midrst_no_rsp", {31'd0, RSP_VALID}, 32'd0);
         chk("midrst_idle", {31'd0, BUSY}, 32'd0);
      end
      issue(32'h0000_00F0, 1'b1, 5'd4, 1'b0, 1);
      wait_rsp(0);

`ifdef SHIFT_SEQ_ROTATE_EN
      issue(32'h8000_0001, 1'b1, 5'd4, 1'b1, 1);
      chk("model_rotr4", exp_q[0], 32'h1800_0000);
      wait_rsp(0);
      issue(32'h8000_0001, 1'b0, 5'd1, 1'b1, 1);
      wait_rsp(0);
      for (int i = 0; i < 4; i++) begin
         issue($urandom, 1'($urandom), 5'($urandom), 1'b1, 1);
         wait_rsp(1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
